// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reorder_buffer_pkg
//  Description : Shared widths and the ROB row record for the reorder buffer.
//                The reorder_buffer width parameters default to these
//                constants, and the row fields are sized from them, so a
//                build that changes PREG_W/AREG_W/DATA_W must change these
//                constants to match.
//  Revision    : 1.0 - initial release
// ============================================================================
package reorder_buffer_pkg;

    localparam int c_depth  = 16;
    localparam int c_disp_w = 2;
    localparam int c_wb_n   = 3;
    localparam int c_ret_w  = 2;
    localparam int c_preg_w = 6;
    localparam int c_areg_w = 5;
    localparam int c_data_w = 32;

    // One ROB entry. v marks an allocated slot; comp marks a result written.
    typedef struct packed {
        logic                v;
        logic                comp;
        logic                is_store;
        logic [c_areg_w-1:0] areg;
        logic [c_preg_w-1:0] phy_reg;
        logic [c_preg_w-1:0] old_phy;
        logic [c_data_w-1:0] result;
    } rob_row_t;

endpackage
`default_nettype wire

// File: rtl/reorder_buffer_retire_sel.sv
`default_nettype none
// ============================================================================
//  Module      : rob_retire_sel
//  Description : Combinational retire selector. Starting at head, finds the
//                longest run of valid+complete entries, capped at RET_W.
//  Ports       : head_i      - current head pointer
//                v_i/comp_i  - per-entry valid and complete flags
//                ret_mask_o  - lane k retires (always a prefix of lanes)
//                n_ret_o     - number of lanes retiring
//                idx_o       - ROB index examined by each lane (head + k)
//  Revision    : 1.0 - initial release
// ============================================================================
module rob_retire_sel
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH = c_depth,
    parameter int RET_W = c_ret_w,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic [AW-1:0]             head_i,
    input  logic [DEPTH-1:0]          v_i,
    input  logic [DEPTH-1:0]          comp_i,
    output logic [RET_W-1:0]          ret_mask_o,
    output logic [CW-1:0]             n_ret_o,
    output logic [RET_W-1:0][AW-1:0]  idx_o
);

    logic w_run;

    always_comb begin
        w_run      = 1'b1;
        n_ret_o    = '0;
        ret_mask_o = '0;
        idx_o      = '0;
        for (int k = 0; k < RET_W; k++) begin
            // Index arithmetic wraps naturally at AW bits.
            idx_o[k]      = head_i + AW'(k);
            // Once one entry fails, every later lane is blocked.
            w_run         = w_run & v_i[idx_o[k]] & comp_i[idx_o[k]];
            ret_mask_o[k] = w_run;
            if (w_run) begin
                n_ret_o = n_ret_o + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : reorder_buffer
//  Description : Circular reorder buffer. Multi-lane compacted dispatch,
//                multi-port writeback (higher port wins on same tag) and
//                in-order registered retire of up to RET_W entries per cycle.
//  Ports       : clk, rst (sync, active high)
//                disp_*_i / disp_ready_o / disp_tag_o - dispatch
//                wb_*_i                               - FU writeback
//                rt_*_o                               - registered retire
//                count_o / empty_o / full_o           - occupancy
//                fwd_*_o (only with ROB_FWD_EN)       - registered result
//                                                       forwarding
//  Macro       : ROB_FWD_EN - adds the fwd_* result forwarding ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH  = c_depth,
    parameter int DISP_W = c_disp_w,
    parameter int WB_N   = c_wb_n,
    parameter int RET_W  = c_ret_w,
    parameter int PREG_W = c_preg_w,
    parameter int AREG_W = c_areg_w,
    parameter int DATA_W = c_data_w
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DISP_W-1:0]                    disp_valid_i,
    input  logic [DISP_W-1:0][PREG_W-1:0]        disp_pd_i,
    input  logic [DISP_W-1:0][PREG_W-1:0]        disp_old_pd_i,
    input  logic [DISP_W-1:0][AREG_W-1:0]        disp_areg_i,
    input  logic [DISP_W-1:0]                    disp_is_store_i,
    output logic                                 disp_ready_o,
    output logic [DISP_W-1:0][$clog2(DEPTH)-1:0] disp_tag_o,
    input  logic [WB_N-1:0]                      wb_valid_i,
    input  logic [WB_N-1:0][$clog2(DEPTH)-1:0]   wb_tag_i,
    input  logic [WB_N-1:0][DATA_W-1:0]          wb_data_i,
    output logic [RET_W-1:0]                     rt_valid_o,
    output logic [RET_W-1:0][AREG_W-1:0]         rt_areg_o,
    output logic [RET_W-1:0][DATA_W-1:0]         rt_data_o,
    output logic [RET_W-1:0][PREG_W-1:0]         rt_free_pd_o,
    output logic [RET_W-1:0]                     rt_is_store_o,
`ifdef ROB_FWD_EN
    output logic [WB_N-1:0]                      fwd_valid_o,
    output logic [WB_N-1:0][PREG_W-1:0]          fwd_pd_o,
    output logic [WB_N-1:0][DATA_W-1:0]          fwd_data_o,
`endif
    output logic [$clog2(DEPTH):0]               count_o,
    output logic                                 empty_o,
    output logic                                 full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_depth_cnt = CW'(DEPTH);

    rob_row_t                  rows_q [DEPTH];
    rob_row_t                  rows_d [DEPTH];
    logic [AW-1:0]             head_q, head_d;
    logic [AW-1:0]             tail_q, tail_d;
    logic [CW-1:0]             count_q, count_d;

    logic [DEPTH-1:0]          w_v;
    logic [DEPTH-1:0]          w_comp;
    logic [CW-1:0]             w_n_valid;
    logic [CW-1:0]             w_n_alloc;
    logic [CW-1:0]             w_n_ret;
    logic [RET_W-1:0]          w_ret_mask;
    logic [RET_W-1:0][AW-1:0]  w_ret_idx;
    logic [WB_N-1:0]           w_wb_acc;

    logic [RET_W-1:0]              rt_valid_q;
    logic [RET_W-1:0][AREG_W-1:0]  rt_areg_q;
    logic [RET_W-1:0][DATA_W-1:0]  rt_data_q;
    logic [RET_W-1:0][PREG_W-1:0]  rt_free_pd_q;
    logic [RET_W-1:0]              rt_is_store_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_v[i]    = rows_q[i].v;
            w_comp[i] = rows_q[i].comp;
        end
    end

    rob_retire_sel #(
        .DEPTH (DEPTH),
        .RET_W (RET_W)
    ) u_retire_sel (
        .head_i     (head_q),
        .v_i        (w_v),
        .comp_i     (w_comp),
        .ret_mask_o (w_ret_mask),
        .n_ret_o    (w_n_ret),
        .idx_o      (w_ret_idx)
    );

    // Compacted tags: each lane gets tail plus the number of valid lanes
    // below it, so an idle lane never consumes a slot.
    always_comb begin
        w_n_valid  = '0;
        disp_tag_o = '0;
        for (int l = 0; l < DISP_W; l++) begin
            disp_tag_o[l] = tail_q + w_n_valid[AW-1:0];
            if (disp_valid_i[l]) begin
                w_n_valid = w_n_valid + CW'(1);
            end
        end
    end

    // Uses occupancy before this edge's retires: freed slots become usable
    // only in the following cycle.
    assign disp_ready_o = ((c_depth_cnt - count_q) >= CW'(DISP_W));
    assign w_n_alloc    = disp_ready_o ? w_n_valid : '0;

    // Acceptance looks at the registered row, so an entry completed by one
    // port is still writable by a higher port in the same cycle.
    always_comb begin
        for (int p = 0; p < WB_N; p++) begin
            w_wb_acc[p] = wb_valid_i[p] && rows_q[wb_tag_i[p]].v
                          && !rows_q[wb_tag_i[p]].comp;
        end
    end

    // Retire clears, writebacks and allocations touch disjoint rows: retiring
    // rows are already complete (writeback ignores them) and allocation only
    // targets free slots because of the pre-retire ready check.
    always_comb begin
        rows_d = rows_q;
        for (int k = 0; k < RET_W; k++) begin
            if (w_ret_mask[k]) begin
                rows_d[w_ret_idx[k]] = '0;
            end
        end
        // Ascending port order makes the highest port win on a shared tag.
        for (int p = 0; p < WB_N; p++) begin
            if (w_wb_acc[p]) begin
                rows_d[wb_tag_i[p]].comp   = 1'b1;
                rows_d[wb_tag_i[p]].result = wb_data_i[p];
            end
        end
        if (disp_ready_o) begin
            for (int l = 0; l < DISP_W; l++) begin
                if (disp_valid_i[l]) begin
                    rows_d[disp_tag_o[l]].v        = 1'b1;
                    rows_d[disp_tag_o[l]].comp     = 1'b0;
                    rows_d[disp_tag_o[l]].is_store = disp_is_store_i[l];
                    rows_d[disp_tag_o[l]].areg     = disp_areg_i[l];
                    rows_d[disp_tag_o[l]].phy_reg  = disp_pd_i[l];
                    rows_d[disp_tag_o[l]].old_phy  = disp_old_pd_i[l];
                    rows_d[disp_tag_o[l]].result   = '0;
                end
            end
        end
        head_d  = head_q + w_n_ret[AW-1:0];
        tail_d  = tail_q + w_n_alloc[AW-1:0];
        count_d = count_q + w_n_alloc - w_n_ret;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            rt_valid_q    <= '0;
            rt_areg_q     <= '0;
            rt_data_q     <= '0;
            rt_free_pd_q  <= '0;
            rt_is_store_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rows_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rows_q  <= rows_d;
            for (int k = 0; k < RET_W; k++) begin
                if (w_ret_mask[k]) begin
                    rt_valid_q[k]    <= 1'b1;
                    rt_areg_q[k]     <= rows_q[w_ret_idx[k]].areg;
                    rt_data_q[k]     <= rows_q[w_ret_idx[k]].result;
                    rt_free_pd_q[k]  <= rows_q[w_ret_idx[k]].old_phy;
                    rt_is_store_q[k] <= rows_q[w_ret_idx[k]].is_store;
                end else begin
                    rt_valid_q[k]    <= 1'b0;
                    rt_areg_q[k]     <= '0;
                    rt_data_q[k]     <= '0;
                    rt_free_pd_q[k]  <= '0;
                    rt_is_store_q[k] <= 1'b0;
                end
            end
        end
    end

`ifdef ROB_FWD_EN
    logic [WB_N-1:0]              fwd_valid_q;
    logic [WB_N-1:0][PREG_W-1:0]  fwd_pd_q;
    logic [WB_N-1:0][DATA_W-1:0]  fwd_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_valid_q <= '0;
            fwd_pd_q    <= '0;
            fwd_data_q  <= '0;
        end else begin
            fwd_valid_q <= w_wb_acc;
            for (int p = 0; p < WB_N; p++) begin
                if (w_wb_acc[p]) begin
                    fwd_pd_q[p]   <= rows_q[wb_tag_i[p]].phy_reg;
                    fwd_data_q[p] <= wb_data_i[p];
                end
            end
        end
    end

    assign fwd_valid_o = fwd_valid_q;
    assign fwd_pd_o    = fwd_pd_q;
    assign fwd_data_o  = fwd_data_q;
`endif

    assign rt_valid_o    = rt_valid_q;
    assign rt_areg_o     = rt_areg_q;
    assign rt_data_o     = rt_data_q;
    assign rt_free_pd_o  = rt_free_pd_q;
    assign rt_is_store_o = rt_is_store_q;
    assign count_o       = count_q;
    assign empty_o       = (count_q == '0);
    assign full_o        = (count_q == c_depth_cnt);

endmodule
`default_nettype wire

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16: entry count; power of two and at least 4.
REQ-002 SHALL have parameter DISP_W, default 2: dispatch lanes per cycle.
REQ-003 SHALL have parameter WB_N, default 3: writeback ports, one per FU.
REQ-004 SHALL have parameter RET_W, default 2: maximum retires per cycle.
REQ-005 SHALL have parameters PREG_W=6, AREG_W=5 and DATA_W=32: physical-register, architectural-register and data widths.
REQ-006 SHALL expose: clk  in  1  clock; all state updates on the rising edge.
REQ-007 SHALL expose: rst  in  1  synchronous, active-high reset.
REQ-008 SHALL expose: disp_valid  in  DISP_W  per-lane dispatch request.
REQ-009 SHALL expose: disp_pd, disp_old_pd  in  DISP_W x PREG_W  new and previous physical destination.
REQ-010 SHALL expose: disp_areg  in  DISP_W x AREG_W  architectural destination; disp_is_store  in  DISP_W  store flag (SW).
REQ-011 SHALL expose: disp_ready  out  1  all requesting lanes are accepted this cycle.
REQ-012 SHALL expose: disp_tag  out  DISP_W x log2(DEPTH)  ROB index assigned to each lane.
REQ-013 SHALL expose: wb_valid  in  WB_N, wb_tag  in  WB_N x log2(DEPTH), wb_data  in  WB_N x DATA_W  FU results.
REQ-014 SHALL expose: rt_valid  out  RET_W, rt_areg  out  RET_W x AREG_W, rt_data  out  RET_W x DATA_W, rt_free_pd  out  RET_W x PREG_W, rt_is_store  out  RET_W.
REQ-015 SHALL expose: count  out  log2(DEPTH)+1  occupied entries; empty and full  out  1 each.

Function
REQ-016 SHALL operate as a circular buffer with head and tail pointers wrapping from DEPTH-1 to 0.
REQ-017 disp_ready SHALL be 1 iff (DEPTH - count) >= DISP_W, using count before this cycle's retires; retire-freed slots are not reusable in the same cycle.
REQ-018 Dispatch SHALL be all-or-nothing: when disp_ready is 1, every valid lane allocates on the edge.
REQ-019 Valid lanes SHALL be compacted in lane order, so an invalid lane does not consume a slot.
REQ-020 disp_tag SHALL be combinational and equal tail + (number of valid lanes below it), mod DEPTH.
REQ-021 On an accepted writeback, the entry's result SHALL be written and comp set on that edge.
REQ-022 A writeback to an invalid or already-complete entry SHALL be ignored.
REQ-023 If two writeback ports hit the same tag in one cycle, the higher port index SHALL win.
REQ-024 Retire SHALL pop, in order from head, the longest run of valid, complete entries, up to RET_W; it stops at the first incomplete entry.
REQ-025 rt_* SHALL be registered and assert for exactly one cycle after the popping edge; unused lanes drive rt_valid=0.
REQ-026 For a store, rt_is_store=1, the consumer ignores rt_areg, and rt_free_pd = old_phy.
REQ-027 Minimum latency SHALL be: writeback at edge N -> pop at edge N+1 -> rt_valid visible in the following cycle.
REQ-028 Popped entries SHALL be cleared, and count SHALL update by (allocated - retired) on each edge.
REQ-029 Simultaneous dispatch, writeback and retire in the same cycle SHALL all take effect with no lost update.
REQ-030 A writeback to a head entry in the same cycle it is evaluated for retire SHALL NOT retire it until the next edge.

Reset
REQ-031 While rst=1 at an edge: head=tail=count=0, all entries v=comp=0, rt_valid=0, all other rt_* outputs = 0, full=0, empty=1, disp_ready=1.
REQ-032 Reset asserted mid-operation SHALL discard all entries, with no retire outputs generated for them.

Configuration
REQ-033 With ROB_FWD_EN defined: ports fwd_valid (out, WB_N), fwd_pd (out, WB_N x PREG_W) and fwd_data (out, WB_N x DATA_W) SHALL be present.
REQ-034 With ROB_FWD_EN defined: fwd_* SHALL be registered copies of each accepted writeback (the entry's phy_reg and the data), valid one cycle after wb_valid; reset value 0.
REQ-035 Without ROB_FWD_EN: the fwd_* ports and their logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-036 Package p SHALL hold the rob_row typedef (v, comp, is_store, areg, phy_reg, old_phy, result) and the default width constants.
REQ-037 A combinational sub-module rob_retire_sel SHALL compute the retire count and lane indices from head and the comp/v vectors.

Verification
REQ-038 Reset then dispatch lanes 0,1 (pd 33,34): tags 0,1 allocated, count=2; wb tag1 then tag0 -> both retire in one cycle, rt_valid=2'b11 in order 33,34.
REQ-039 Fill 16 entries: full=1 and disp_ready=0; retire 2 -> disp_ready=1 the next cycle, not the same cycle.
REQ-040 Wrap-around: head=14 with 4 entries; entries 14,15,0,1 complete -> two retire cycles, head ends at 2.
REQ-041 disp_valid=2'b10: lane 1 receives tag=tail, and tail advances by 1.
REQ-042 wb ports 0 and 2 both target tag 5 with data 7 and 9 -> retired rt_data=9.
REQ-043 Store entry (is_store=1, old_pd=12) completes -> rt_is_store=1, rt_free_pd=12; with ROB_FWD_EN, fwd_valid pulses one cycle after the writeback.
